// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared state type and round-robin pick helper for the L2 stall port arbiter
package l2_arb_pkg;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  localparam int MAX_N = 32;
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int n, input int ptr);
    int idx;
    rr_pick = ptr;
    // Walk downward so the requester closest to ptr wins.
    for (int k = MAX_N - 1; k >= 0; k--) begin
      idx = (ptr + k >= n) ? ptr + k - n : ptr + k;
      if (k < n && req[idx[4:0]]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module l2_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_MASTER = 4,
  parameter int LOG_N    = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [LOG_N-1:0]    ptr,
  output logic [LOG_N-1:0]    sel,
  output logic                valid
);
  assign valid = |req;
  assign sel   = LOG_N'(rr_pick(MAX_N'(req), N_MASTER, int'(ptr)));
endmodule

// File: rtl/l2_stall_port_arbiter.sv
// l2_stall_port_arbiter: round-robin sharing of one stalling L2 SRAM port with
// stall hold, outstanding-transaction throttle and tag-based response routing.
module l2_stall_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int MAX_OUT    = 8,
  parameter int LOG_N      = $clog2(N_MASTER),
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [N_MASTER-1:0]            m_req_i,
  output logic [N_MASTER-1:0]            m_gnt_o,
  input  logic [N_MASTER-1:0]            m_wen_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_add_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   m_be_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]   m_id_i,
  output logic [N_MASTER-1:0]            m_r_valid_o,
  input  logic [N_MASTER-1:0]            m_r_gnt_i,
  output logic [DATA_WIDTH-1:0]          m_r_rdata_o,
  output logic [ID_WIDTH-1:0]            m_r_id_o,
  output logic                           mem_cen_o,
  output logic                           mem_wen_o,
  output logic [ADDR_WIDTH-1:0]          mem_a_o,
  output logic [DATA_WIDTH-1:0]          mem_d_o,
  output logic [BE_WIDTH-1:0]            mem_be_o,
  output logic [LOG_N-1:0]               mem_id_o,
  output logic [ID_WIDTH-1:0]            mem_aux_o,
  input  logic                           mem_gnt_i,
  input  logic [DATA_WIDTH-1:0]          mem_q_i,
  input  logic [LOG_N-1:0]               mem_r_id_i,
  input  logic [ID_WIDTH-1:0]            mem_r_aux_i,
  input  logic                           mem_r_valid_i,
  output logic                           mem_r_gnt_o,
  output logic [CNT_W-1:0]               outstanding_o
);
  arb_state_e       state;
  logic [LOG_N-1:0] sel_q, rr_ptr, arb_sel, cur_sel, nxt;
  logic [CNT_W-1:0] count;
  logic             arb_valid, throttle, req_act, accept, pop;

  l2_rr_arbiter #(.N_MASTER(N_MASTER), .LOG_N(LOG_N)) u_rr (
    .req   (m_req_i),
    .ptr   (rr_ptr),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  // A stalled request keeps its master; a dropped request abandons the hold.
  assign cur_sel  = state == HOLD ? sel_q : arb_sel;
  assign throttle = count == CNT_W'(MAX_OUT);
  assign req_act  = RSTN && !throttle && (state == HOLD ? m_req_i[sel_q] : arb_valid);
  assign accept   = req_act && mem_gnt_i;
  assign pop      = mem_r_valid_i && mem_r_gnt_o;
  assign nxt      = cur_sel == LOG_N'(N_MASTER - 1) ? '0 : cur_sel + 1'b1;

  assign mem_cen_o = !req_act;
  assign m_gnt_o   = accept ? N_MASTER'(1) << cur_sel : '0;
  assign mem_wen_o = m_wen_i[cur_sel];
  assign mem_a_o   = m_add_i[cur_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_d_o   = m_wdata_i[cur_sel*DATA_WIDTH +: DATA_WIDTH];
  assign mem_be_o  = m_be_i[cur_sel*BE_WIDTH +: BE_WIDTH];
  assign mem_aux_o = m_id_i[cur_sel*ID_WIDTH +: ID_WIDTH];
  assign mem_id_o  = cur_sel;

  assign m_r_valid_o   = mem_r_valid_i ? N_MASTER'(1) << mem_r_id_i : '0;
  assign m_r_rdata_o   = mem_q_i;
  assign m_r_id_o      = mem_r_aux_i;
  assign mem_r_gnt_o   = m_r_gnt_i[mem_r_id_i];
  assign outstanding_o = count;

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state  <= IDLE;
      sel_q  <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      if (accept) begin
        state  <= IDLE;
        rr_ptr <= nxt;
      end else if (state == IDLE && req_act) begin
        state <= HOLD;
        sel_q <= arb_sel;
      end else if (state == HOLD && !m_req_i[sel_q]) state <= IDLE;
    end

  assert property (@(posedge CLK) disable iff (!RSTN) !(accept && !pop && throttle));
  assert property (@(posedge CLK) disable iff (!RSTN) !(pop && !accept && count == '0));
endmodule

// File: tb/tb_l2_stall_port_arbiter.sv
// tb_l2_stall_port_arbiter: stalling SRAM model plus response scoreboard keyed by master and id
module tb_l2_stall_port_arbiter;
  localparam int N = 4, AW = 20, DW = 32, IW = 3, BW = 4, LN = 2, CW = 4;

  typedef struct packed {logic [LN-1:0] m; logic [IW-1:0] id; logic [DW-1:0] d;} exp_t;
  typedef struct packed {logic [LN-1:0] id; logic [IW-1:0] aux; logic [DW-1:0] q;} rsp_t;

  logic CLK = 0, RSTN = 0;
  logic [N-1:0] m_req_i = '0, m_gnt_o, m_wen_i = '0, m_r_valid_o, m_r_gnt_i = '0;
  logic [N*AW-1:0] m_add_i = '0;
  logic [N*DW-1:0] m_wdata_i = '0;
  logic [N*BW-1:0] m_be_i = '0;
  logic [N*IW-1:0] m_id_i = '0;
  logic [DW-1:0] m_r_rdata_o, mem_d_o, hq = '0;
  logic [IW-1:0] m_r_id_o, mem_aux_o, haux = '0;
  logic mem_cen_o, mem_wen_o, mem_gnt_i = 0, mem_r_gnt_o, hv = 0;
  logic [AW-1:0] mem_a_o;
  logic [BW-1:0] mem_be_o;
  logic [LN-1:0] mem_id_o, hid = '0;
  logic [CW-1:0] outstanding_o;

  int checks = 0, failures = 0;
  exp_t sb[$];
  rsp_t fq[$];
  logic [DW-1:0] sram [256];

  always #5 CLK = ~CLK;

  l2_stall_port_arbiter dut (
    .CLK(CLK), .RSTN(RSTN), .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_wen_i(m_wen_i),
    .m_add_i(m_add_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_id_i(m_id_i),
    .m_r_valid_o(m_r_valid_o), .m_r_gnt_i(m_r_gnt_i), .m_r_rdata_o(m_r_rdata_o),
    .m_r_id_o(m_r_id_o), .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_a_o(mem_a_o),
    .mem_d_o(mem_d_o), .mem_be_o(mem_be_o), .mem_id_o(mem_id_o), .mem_aux_o(mem_aux_o),
    .mem_gnt_i(mem_gnt_i), .mem_q_i(hq), .mem_r_id_i(hid), .mem_r_aux_i(haux),
    .mem_r_valid_i(hv), .mem_r_gnt_o(mem_r_gnt_o), .outstanding_o(outstanding_o)
  );

  function automatic logic [DW-1:0] iv(input logic [AW-1:0] a);
    return 32'hA000_0000 | {12'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic wen, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, input logic [IW-1:0] id);
    m_wen_i[m] = wen;
    m_add_i[m*AW +: AW] = a;
    m_wdata_i[m*DW +: DW] = d;
    m_be_i[m*BW +: BW] = be;
    m_id_i[m*IW +: IW] = id;
  endtask

  task automatic push(input logic [LN-1:0] m, input logic [IW-1:0] id, input logic [DW-1:0] d);
    sb.push_back('{m: m, id: id, d: d});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
    #1;
    chk({tag, "_drain"}, sb.size(), 0);
    chk({tag, "_cnt0"}, outstanding_o, 0);
  endtask

  // Stalling SRAM: in-order response FIFO, a response for every accepted request.
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      fq.delete();
      hv <= 1'b0;
      for (int i = 0; i < 256; i++) sram[i] <= iv(AW'(i));
    end else begin
      if (hv && mem_r_gnt_o) void'(fq.pop_front());
      if (!mem_cen_o && mem_gnt_i) begin
        if (mem_wen_o) fq.push_back('{id: mem_id_o, aux: mem_aux_o, q: sram[mem_a_o[7:0]]});
        else begin
          for (int b = 0; b < BW; b++)
            if (mem_be_o[b]) sram[mem_a_o[7:0]][8*b +: 8] <= mem_d_o[8*b +: 8];
          fq.push_back('{id: mem_id_o, aux: mem_aux_o, q: '0});
        end
      end
      hv <= fq.size() != 0;
      if (fq.size() != 0) begin
        hid  <= fq[0].id;
        haux <= fq[0].aux;
        hq   <= fq[0].q;
      end
    end

  always @(negedge CLK) begin
    #3;
    if (RSTN && (m_r_valid_o & m_r_gnt_i) != 0) begin
      chk("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("rsp_valid", m_r_valid_o, 4'b0001 << sb[0].m);
        chk("rsp_id", m_r_id_o, sb[0].id);
        chk("rsp_data", m_r_rdata_o, sb[0].d);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < N; m++) set_m(m, 1'b1, AW'(m), '0, 4'hF, IW'(m));
    m_req_i = 4'b1111;
    mem_gnt_i = 1;
    m_r_gnt_i = 4'hF;
    repeat (2) begin
      @(negedge CLK); #1;
      chk("rst_cen", mem_cen_o, 1);
      chk("rst_gnt", m_gnt_o, 0);
      chk("rst_rvalid", m_r_valid_o, 0);
      chk("rst_cnt", outstanding_o, 0);
    end
    @(negedge CLK);
    RSTN = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", m_gnt_o, 4'b0001 << (i % N));
      push(LN'(i % N), IW'(i % N), iv(AW'(i % N)));
      @(negedge CLK);
    end
    m_req_i = '0;
    drain("rr");

    mem_gnt_i = 0;
    set_m(2, 1'b1, 20'h20, '0, 4'hF, 3'd2);
    m_req_i = 4'b0100;
    #1;
    chk("hold_cen", mem_cen_o, 0);
    chk("hold_gnt", m_gnt_o, 0);
    chk("hold_a1", mem_a_o, 20'h20);
    @(negedge CLK);
    m_req_i[0] = 1;
    #1;
    chk("hold_a2", mem_a_o, 20'h20);
    chk("hold_id2", mem_id_o, 2);
    @(negedge CLK); #1;
    chk("hold_a3", mem_a_o, 20'h20);
    @(negedge CLK);
    mem_gnt_i = 1;
    #1;
    chk("hold_acc", m_gnt_o, 4'b0100);
    push(2, 3'd2, iv(20'h20));
    @(negedge CLK);
    m_req_i[2] = 0;
    #1;
    chk("hold_next", m_gnt_o, 4'b0001);
    push(0, 3'd0, iv(20'h0));
    @(negedge CLK);
    m_req_i = '0;
    drain("hold");

    m_r_gnt_i = '0;
    set_m(1, 1'b1, 20'h30, '0, 4'hF, 3'd3);
    m_req_i = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("thr_gnt", m_gnt_o, 4'b0010);
      push(1, 3'd3, iv(20'h30));
      @(negedge CLK);
    end
    #1;
    chk("thr_cnt8", outstanding_o, 8);
    chk("thr_cen", mem_cen_o, 1);
    chk("thr_nogt", m_gnt_o, 0);
    m_r_gnt_i = 4'b0010;
    #1;
    chk("thr_cen_pop", mem_cen_o, 1);
    @(negedge CLK); #1;
    chk("thr_cnt7", outstanding_o, 7);
    chk("thr_resume", m_gnt_o, 4'b0010);
    push(1, 3'd3, iv(20'h30));
    @(negedge CLK);
    m_req_i = '0;
    m_r_gnt_i = 4'hF;
    drain("thr");

    set_m(1, 1'b0, 20'h10, 32'hDEADBEEF, 4'b0011, 3'd1);
    m_req_i = 4'b0010;
    #1;
    chk("wr_gnt", m_gnt_o, 4'b0010);
    push(1, 3'd1, '0);
    @(negedge CLK);
    set_m(3, 1'b1, 20'h10, '0, 4'hF, 3'd5);
    m_req_i = 4'b1000;
    #1;
    chk("rd_gnt", m_gnt_o, 4'b1000);
    push(3, 3'd5, (iv(20'h10) & 32'hFFFF_0000) | 32'h0000_BEEF);
    @(negedge CLK);
    m_req_i = '0;
    drain("wr_rd");

    m_r_gnt_i = '0;
    set_m(0, 1'b1, 20'h40, '0, 4'hF, 3'd4);
    m_req_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("both_gnt", m_gnt_o, 4'b0001);
      push(0, 3'd4, iv(20'h40));
      @(negedge CLK);
    end
    m_r_gnt_i = 4'hF;
    #1;
    chk("both_acc", m_gnt_o, 4'b0001);
    chk("both_rv", m_r_valid_o, 4'b0001);
    push(0, 3'd4, iv(20'h40));
    @(negedge CLK);
    m_req_i = '0;
    #1;
    chk("both_cnt4", outstanding_o, 4);
    drain("both");

    m_r_gnt_i = '0;
    set_m(2, 1'b1, 20'h50, '0, 4'hF, 3'd6);
    m_req_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_gnt", m_gnt_o, 4'b0100);
      push(2, 3'd6, iv(20'h50));
      @(negedge CLK);
    end
    mem_gnt_i = 0;
    #1;
    chk("mid_cen", mem_cen_o, 0);
    @(negedge CLK); #1;
    chk("mid_cnt3", outstanding_o, 3);
    chk("mid_rv", m_r_valid_o, 4'b0100);
    chk("mid_sel", mem_id_o, 2);
    #1;
    RSTN = 0;
    #1;
    chk("arst_cnt", outstanding_o, 0);
    chk("arst_rv", m_r_valid_o, 0);
    chk("arst_cen", mem_cen_o, 1);
    sb.delete();
    @(negedge CLK);
    RSTN = 1;
    m_req_i = 4'b0001;
    mem_gnt_i = 1;
    #1;
    chk("arst_idle", m_gnt_o, 4'b0001);
    push(0, 3'd4, iv(20'h40));
    @(negedge CLK);
    m_req_i = '0;
    m_r_gnt_i = 4'hF;
    drain("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
